// File: rtl/regblock_stk.sv
// regblock_stk: programmer-visible register file for the 6809/6309-compatible core, with a
// byte-serial PSH/PUL stack sequencer driving a req/ack byte memory port.
//
// Ports:
//   clk_in, reset_in          clock, synchronous active-high reset
//   rd_addr_a/b, rd_data_a/b  two combinational 16-bit read ports (4-bit register codes)
//   wr_en, wr_addr, wr_data   write port; exg_en swaps the registers named by rd_addr_a/b
//   pc_inc                    PC increment (lowest write priority)
//   stk_start, stk_pull, stk_use_s, stk_mask   stack sequencer command (6809 postbyte mask)
//   stk_busy, stk_done        sequencer status; done is a one-cycle pulse
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack   byte memory handshake
//   ccr_o, reg_pc, reg_dp     direct views of CC, PC and DP
module regblock_stk #(
  parameter bit          CPU_6309 = 1'b0,
  parameter logic [15:0] RESET_PC = 16'hFFFE,
  parameter logic [7:0]  RESET_CC = 8'h50
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [3:0]  rd_addr_a,
  output logic [15:0] rd_data_a,
  input  logic [3:0]  rd_addr_b,
  output logic [15:0] rd_data_b,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        exg_en,
  input  logic        pc_inc,
  input  logic        stk_start,
  input  logic        stk_pull,
  input  logic        stk_use_s,
  input  logic [7:0]  stk_mask,
  output logic        stk_busy,
  output logic        stk_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  ccr_o,
  output logic [15:0] reg_pc,
  output logic [7:0]  reg_dp
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} stk_state_e;

  // Upper byte returned by 8-bit register reads.
  localparam logic [7:0] Hi8 = CPU_6309 ? 8'h00 : 8'hFF;

  logic [7:0]  a_q, a_d, b_q, b_d, dp_q, dp_d, cc_q, cc_d, e_q, e_d, f_q, f_d;
  logic [15:0] x_q, x_d, y_q, y_d, u_q, u_d, s_q, s_d, pc_q, pc_d, v_q, v_d;

  stk_state_e  state_q;
  logic [11:0] pending_q;  // bytes still to move, indexed in push order (0 = PCL .. 11 = CC)
  logic        pull_q, use_s_q;

  logic [3:0]  cur_idx;
  logic [11:0] pending_rest;
  logic [15:0] sp, other_sp;
  logic [1:0]  wc_en;
  logic [1:0][3:0]  wc_code;
  logic [1:0][15:0] wc_data;

  function automatic logic [15:0] read_reg(input logic [3:0] code);
    case (code)
      4'd0:    return {a_q, b_q};
      4'd1:    return x_q;
      4'd2:    return y_q;
      4'd3:    return u_q;
      4'd4:    return s_q;
      4'd5:    return pc_q;
      4'd6:    return CPU_6309 ? {e_q, f_q} : 16'hFFFF;
      4'd7:    return CPU_6309 ? v_q : 16'hFFFF;
      4'd8:    return {Hi8, a_q};
      4'd9:    return {Hi8, b_q};
      4'd10:   return {Hi8, cc_q};
      4'd11:   return {Hi8, dp_q};
      4'd14:   return CPU_6309 ? {Hi8, e_q} : 16'hFFFF;
      4'd15:   return CPU_6309 ? {Hi8, f_q} : 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  // Postbyte bit -> byte slots in push order.
  function automatic logic [11:0] expand_mask(input logic [7:0] m);
    return {m[0], m[1], m[2], m[3], m[4], m[4], m[5], m[5], m[6], m[6], m[7], m[7]};
  endfunction

  function automatic logic [3:0] first_set(input logic [11:0] v, input logic from_top);
    logic [3:0] r;
    r = 4'd0;
    if (from_top) begin
      for (int i = 0; i < 12; i++) if (v[i]) r = 4'(i);
    end else begin
      for (int i = 11; i >= 0; i--) if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign rd_data_a = read_reg(rd_addr_a);
  assign rd_data_b = read_reg(rd_addr_b);

  // Push walks slots upward, pull walks them downward.
  assign cur_idx      = first_set(pending_q, pull_q);
  assign pending_rest = pending_q & ~(12'd1 << cur_idx);
  assign sp           = use_s_q ? s_q : u_q;
  assign other_sp     = use_s_q ? u_q : s_q;

  assign stk_busy = (state_q != StIdle);
  assign stk_done = (state_q == StDone);
  assign mem_req  = (state_q == StXfer);
  assign mem_we   = mem_req & ~pull_q;
  assign mem_addr = mem_req ? (pull_q ? sp : sp - 16'd1) : 16'h0000;
  assign ccr_o    = cc_q;
  assign reg_pc   = pc_q;
  assign reg_dp   = dp_q;

  always_comb begin
    mem_wdata = 8'h00;
    if (mem_we) begin
      case (cur_idx)
        4'd0:    mem_wdata = pc_q[7:0];
        4'd1:    mem_wdata = pc_q[15:8];
        4'd2:    mem_wdata = other_sp[7:0];
        4'd3:    mem_wdata = other_sp[15:8];
        4'd4:    mem_wdata = y_q[7:0];
        4'd5:    mem_wdata = y_q[15:8];
        4'd6:    mem_wdata = x_q[7:0];
        4'd7:    mem_wdata = x_q[15:8];
        4'd8:    mem_wdata = dp_q;
        4'd9:    mem_wdata = b_q;
        4'd10:   mem_wdata = a_q;
        default: mem_wdata = cc_q;
      endcase
    end
  end

  // Exchange replaces the plain write; both halves use pre-edge read-port values.
  always_comb begin
    wc_en   = 2'b00;
    wc_code = '0;
    wc_data = '0;
    if (exg_en) begin
      wc_en      = 2'b11;
      wc_code[0] = rd_addr_a;
      wc_data[0] = rd_data_b;
      wc_code[1] = rd_addr_b;
      wc_data[1] = rd_data_a;
    end else if (wr_en) begin
      wc_en[0]   = 1'b1;
      wc_code[0] = wr_addr;
      wc_data[0] = wr_data;
    end
  end

  always_comb begin
    a_d = a_q;  b_d = b_q;  dp_d = dp_q;  cc_d = cc_q;  e_d = e_q;  f_d = f_q;
    x_d = x_q;  y_d = y_q;  u_d = u_q;    s_d = s_q;    pc_d = pc_q; v_d = v_q;
    if (state_q == StIdle) begin
      if (pc_inc) pc_d = pc_q + 16'd1;
      for (int p = 0; p < 2; p++) begin
        if (wc_en[p]) begin
          case (wc_code[p])
            4'd0:  begin a_d = wc_data[p][15:8]; b_d = wc_data[p][7:0]; end
            4'd1:  x_d = wc_data[p];
            4'd2:  y_d = wc_data[p];
            4'd3:  u_d = wc_data[p];
            4'd4:  s_d = wc_data[p];
            4'd5:  pc_d = wc_data[p];
            4'd6:  if (CPU_6309) begin e_d = wc_data[p][15:8]; f_d = wc_data[p][7:0]; end
            4'd7:  if (CPU_6309) v_d = wc_data[p];
            4'd8:  a_d = wc_data[p][7:0];
            4'd9:  b_d = wc_data[p][7:0];
            4'd10: cc_d = wc_data[p][7:0];
            4'd11: dp_d = wc_data[p][7:0];
            4'd14: if (CPU_6309) e_d = wc_data[p][7:0];
            4'd15: if (CPU_6309) f_d = wc_data[p][7:0];
            default: ;
          endcase
        end
      end
    end else if (state_q == StXfer && mem_ack) begin
      if (use_s_q) s_d = pull_q ? s_q + 16'd1 : s_q - 16'd1;
      else         u_d = pull_q ? u_q + 16'd1 : u_q - 16'd1;
      if (pull_q) begin
        case (cur_idx)
          4'd0:  pc_d[7:0]  = mem_rdata;
          4'd1:  pc_d[15:8] = mem_rdata;
          4'd2:  if (use_s_q) u_d[7:0]  = mem_rdata; else s_d[7:0]  = mem_rdata;
          4'd3:  if (use_s_q) u_d[15:8] = mem_rdata; else s_d[15:8] = mem_rdata;
          4'd4:  y_d[7:0]  = mem_rdata;
          4'd5:  y_d[15:8] = mem_rdata;
          4'd6:  x_d[7:0]  = mem_rdata;
          4'd7:  x_d[15:8] = mem_rdata;
          4'd8:  dp_d = mem_rdata;
          4'd9:  b_d = mem_rdata;
          4'd10: a_d = mem_rdata;
          default: cc_d = mem_rdata;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      a_q <= 8'h00;  b_q <= 8'h00;  dp_q <= 8'h00;  cc_q <= RESET_CC;
      e_q <= 8'h00;  f_q <= 8'h00;  x_q <= 16'h0000; y_q <= 16'h0000;
      u_q <= 16'h0000; s_q <= 16'h0000; pc_q <= RESET_PC; v_q <= 16'h0000;
    end else begin
      a_q <= a_d;  b_q <= b_d;  dp_q <= dp_d;  cc_q <= cc_d;
      e_q <= e_d;  f_q <= f_d;  x_q <= x_d;    y_q <= y_d;
      u_q <= u_d;  s_q <= s_d;  pc_q <= pc_d;  v_q <= v_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= StIdle;
      pending_q <= 12'd0;
      pull_q    <= 1'b0;
      use_s_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (stk_start) begin
            pull_q    <= stk_pull;
            use_s_q   <= stk_use_s;
            pending_q <= expand_mask(stk_mask);
            state_q   <= (stk_mask == 8'h00) ? StDone : StXfer;
          end
        end
        StXfer: begin
          if (mem_ack) begin
            pending_q <= pending_rest;
            if (pending_rest == 12'd0) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regblock_stk.sv
// Directed bench for regblock_stk: a 6809 instance carries the stack tests, a 6309 instance
// shares its inputs for the W/E/F checks. A byte-array memory answers the req/ack port.
module tb_regblock_stk;

  logic        clk_in = 1'b0;
  logic        reset_in, wr_en, exg_en, pc_inc, stk_start, stk_pull, stk_use_s, mem_ack;
  logic [3:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  stk_mask, mem_rdata;

  logic [15:0] rd_data_a, rd_data_b, mem_addr, reg_pc;
  logic        stk_busy, stk_done, mem_req, mem_we;
  logic [7:0]  mem_wdata, ccr_o, reg_dp;

  logic [15:0] rd_data_a9, rd_data_b9, mem_addr9, reg_pc9;
  logic        stk_busy9, stk_done9, mem_req9, mem_we9;
  logic [7:0]  mem_wdata9, ccr_o9, reg_dp9;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem_arr [65536];
  logic [15:0] wlog_addr [$];
  logic [7:0]  wlog_data [$];
  logic [15:0] rlog_addr [$];
  int          rlog_hold [$];

  logic [7:0] push_exp [12] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h88, 8'h77,
                                8'h66, 8'h55, 8'h9A, 8'h34, 8'h12, 8'hC5};

  always #5 clk_in = ~clk_in;

  regblock_stk #(.CPU_6309(1'b0)) u_dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .exg_en(exg_en), .pc_inc(pc_inc),
    .stk_start(stk_start), .stk_pull(stk_pull), .stk_use_s(stk_use_s), .stk_mask(stk_mask),
    .stk_busy(stk_busy), .stk_done(stk_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ccr_o(ccr_o), .reg_pc(reg_pc), .reg_dp(reg_dp)
  );

  regblock_stk #(.CPU_6309(1'b1)) u_dut9 (
    .clk_in(clk_in), .reset_in(reset_in),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a9), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b9),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .exg_en(exg_en), .pc_inc(pc_inc),
    .stk_start(stk_start), .stk_pull(stk_pull), .stk_use_s(stk_use_s), .stk_mask(stk_mask),
    .stk_busy(stk_busy9), .stk_done(stk_done9), .mem_req(mem_req9), .mem_we(mem_we9),
    .mem_addr(mem_addr9), .mem_wdata(mem_wdata9), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ccr_o(ccr_o9), .reg_pc(reg_pc9), .reg_dp(reg_dp9)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [3:0] code, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_addr = code;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] code, output logic [15:0] v);
    rd_addr_a = code;
    #1;
    v = rd_data_a;
  endtask

  task automatic rd9(input logic [3:0] code, output logic [15:0] v);
    rd_addr_a = code;
    #1;
    v = rd_data_a9;
  endtask

  // Issues one stack command and serves the memory port, acking each byte after dly waits.
  task automatic run_stk(input logic pull, input logic use_s, input logic [7:0] mask,
                         input int dly, output int req_cycles, output int done_cyc);
    int          waitc;
    logic [15:0] held;
    bit          stable;
    wlog_addr.delete(); wlog_data.delete(); rlog_addr.delete(); rlog_hold.delete();
    stk_pull  = pull;
    stk_use_s = use_s;
    stk_mask  = mask;
    stk_start = 1'b1;
    tick();
    stk_start  = 1'b0;
    waitc      = 0;
    held       = 16'h0000;
    stable     = 1'b1;
    req_cycles = 0;
    done_cyc   = -1;
    for (int c = 0; c < 200; c++) begin
      if (stk_done) begin
        done_cyc = c;
        break;
      end
      if (mem_req) begin
        req_cycles++;
        if (waitc == 0) begin
          held   = mem_addr;
          stable = 1'b1;
        end else if (mem_addr !== held) begin
          stable = 1'b0;
        end
        if (waitc == dly) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
          end else begin
            mem_rdata = mem_arr[mem_addr];
            rlog_addr.push_back(mem_addr);
            rlog_hold.push_back(stable ? waitc + 1 : -1);
          end
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      tick();
      mem_ack = 1'b0;
    end
    tick();
  endtask

  initial begin
    logic [15:0] v;
    logic [23:0] got24;
    logic [31:0] got32;
    int          reqs, dcyc, acks;

    reset_in = 1'b1; wr_en = 1'b0; exg_en = 1'b0; pc_inc = 1'b0; stk_start = 1'b0;
    stk_pull = 1'b0; stk_use_s = 1'b0; mem_ack = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    wr_addr = 4'd0; wr_data = 16'h0000; stk_mask = 8'h00; mem_rdata = 8'h00;
    tick();
    tick();
    reset_in = 1'b0;

    rd(4'd5, v); check_val("rst_pc", v, 16'hFFFE);
    check_val("rst_cc", ccr_o, 8'h50);
    rd(4'd4, v); check_val("rst_s", v, 16'h0000);
    rd(4'd3, v); check_val("rst_u", v, 16'h0000);
    rd(4'd1, v); check_val("rst_x", v, 16'h0000);
    check_val("rst_stat", {stk_busy, stk_done, mem_req, mem_we, mem_addr}, 20'h0);

    wr(4'd0, 16'h1234);
    rd(4'd8, v); check_val("rd_a_6809", v, 16'hFF12);
    rd(4'd9, v); check_val("rd_b_6809", v, 16'hFF34);
    rd9(4'd8, v); check_val("rd_a_6309", v, 16'h0012);

    wr(4'd1, 16'h1111);
    wr(4'd2, 16'h2222);
    rd_addr_a = 4'd1; rd_addr_b = 4'd2; exg_en = 1'b1;
    tick();
    exg_en = 1'b0;
    rd(4'd1, v); check_val("exg_x", v, 16'h2222);
    rd(4'd2, v); check_val("exg_y", v, 16'h1111);

    wr(4'd1, 16'h5566);
    wr(4'd2, 16'h7788);
    wr(4'd4, 16'h0F00);
    wr(4'd3, 16'hABCD);
    wr(4'd5, 16'h1234);
    wr(4'd11, 16'h009A);
    wr(4'd10, 16'h00C5);
    check_val("reg_dp", reg_dp, 8'h9A);

    run_stk(1'b0, 1'b1, 8'hFF, 0, reqs, dcyc);
    check_val("push_cnt", wlog_addr.size(), 12);
    for (int i = 0; i < 12; i++) begin
      got24 = 24'hDEAD00;
      if (i < wlog_addr.size()) got24 = {wlog_addr[i], wlog_data[i]};
      check_val($sformatf("push[%0d]", i), got24, {16'h0EFF - 16'(i), push_exp[i]});
    end
    check_val("push_done", dcyc, 12);
    rd(4'd4, v); check_val("push_s", v, 16'h0EF4);
    check_val("push_idle", stk_busy, 1'b0);

    wr(4'd10, 16'h0000);
    wr(4'd5, 16'h0000);
    mem_arr[16'h0EF5] = 8'h5A;
    mem_arr[16'h0EF6] = 8'h3C;
    run_stk(1'b1, 1'b1, 8'h81, 2, reqs, dcyc);
    check_val("pull_cnt", rlog_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got32 = 32'hDEADBEEF;
      if (i < rlog_addr.size()) got32 = {rlog_addr[i], 16'(rlog_hold[i])};
      check_val($sformatf("pull[%0d]", i), got32, {16'h0EF4 + 16'(i), 16'd3});
    end
    check_val("pull_cc", ccr_o, 8'hC5);
    check_val("pull_pc", reg_pc, 16'h5A3C);
    rd(4'd4, v); check_val("pull_s", v, 16'h0EF7);

    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    rd(4'd4, v); check_val("idle_ack", v, 16'h0EF7);

    wr(4'd4, 16'h0000);
    run_stk(1'b0, 1'b1, 8'h01, 0, reqs, dcyc);
    got24 = 24'hDEAD00;
    if (wlog_addr.size() == 1) got24 = {wlog_addr[0], wlog_data[0]};
    check_val("wrap_wr", got24, 24'hFFFFC5);
    rd(4'd4, v); check_val("wrap_s", v, 16'hFFFF);

    run_stk(1'b0, 1'b1, 8'h00, 0, reqs, dcyc);
    check_val("m0_done", dcyc, 0);
    check_val("m0_req", reqs, 0);

    wr(4'd4, 16'h0F00);
    stk_pull = 1'b0; stk_use_s = 1'b1; stk_mask = 8'hFF; stk_start = 1'b1;
    tick();
    stk_start = 1'b0;
    acks = 0;
    for (int c = 0; c < 50 && acks < 3; c++) begin
      if (mem_req) begin
        mem_ack = 1'b1;
        acks++;
      end
      tick();
      mem_ack = 1'b0;
    end
    rd(4'd4, v); check_val("mid_s", v, 16'h0EFD);
    reset_in = 1'b1;
    tick();
    check_val("rstx_req", mem_req, 1'b0);
    check_val("rstx_busy", stk_busy, 1'b0);
    rd(4'd4, v); check_val("rstx_s", v, 16'h0000);
    reset_in = 1'b0;
    check_val("rst9_stat", {stk_busy9, stk_done9, mem_req9, mem_we9, mem_addr9, mem_wdata9},
              28'h0);
    check_val("rst9_regs", {ccr_o9, reg_pc9, reg_dp9}, 32'h50FFFE00);

    wr(4'd6, 16'hBEEF);
    rd9(4'd14, v); check_val("e_6309", v, 16'h00BE);
    rd9(4'd6, v); check_val("w_6309", v, 16'hBEEF);
    rd_addr_b = 4'd15;
    #1;
    check_val("f_6309", rd_data_b9, 16'h00EF);
    rd(4'd6, v); check_val("w_6809", v, 16'hFFFF);
    rd(4'd12, v); check_val("zero12", v, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
